// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage for the SDF FFT output, ping-pong buffered.
// Optional macro BITREV_IDX_EN adds the do_idx output (natural bin index of each output sample).
module bitrev_reorder #(
  parameter  int N     = 64,
  parameter  int WIDTH = 16,
  localparam int LOG_N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
`ifdef BITREV_IDX_EN
  output logic [LOG_N-1:0] do_idx,
`endif
  output logic             frame_err
);

  localparam logic [LOG_N-1:0] CNT_MAX = LOG_N'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // ---------------------------------------------------------------- storage
  logic [2*WIDTH-1:0] mem [0:2*N-1];
  logic [2*WIDTH-1:0] rd_data_q;

  // ---------------------------------------------------------------- writer
  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG_N-1:0] wr_addr;
  logic             wr_bank_q, wr_bank_d;
  logic             drop_q, drop_d;
  logic             frame_err_q, frame_err_d;
  logic             frame_start;
  logic             drop_cur;
  logic             wr_en;
  logic [1:0]       set_full;

  // ---------------------------------------------------------------- reader
  state_t           state_q, state_d;
  logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             other_bank;
  logic [1:0]       clr_full;
  logic [1:0]       full_q, full_d;
  logic [1:0]       full_pre;
  logic             do_en_q;

  genvar gi;
  generate
    for (gi = 0; gi < LOG_N; gi++) begin : g_bitrev
      assign wr_addr[gi] = wr_cnt_q[LOG_N-1-gi];
    end
  endgenerate

  // The drop decision is taken once at the first sample and held for the frame.
  assign frame_start = di_en && (wr_cnt_q == '0);
  assign drop_cur    = frame_start ? full_q[wr_bank_q] : drop_q;
  assign wr_en       = di_en && !drop_cur;

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    drop_d      = drop_q;
    frame_err_d = 1'b0;
    set_full    = 2'b00;
    if (di_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      drop_d   = drop_cur;
      if ((wr_cnt_q == CNT_MAX) && !drop_cur) begin
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end
    end else if (wr_cnt_q != '0) begin
      wr_cnt_d    = '0;
      drop_d      = 1'b0;
      frame_err_d = 1'b1;
    end
  end

  // Reader decisions see a flag being set this cycle, so a frame completing
  // on the same edge as the current read is picked up without a gap.
  assign full_pre   = full_q | set_full;
  assign other_bank = ~rd_bank_q;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    clr_full  = 2'b00;
    case (state_q)
      IDLE: begin
        if (full_pre[rd_bank_q]) begin
          state_d  = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == CNT_MAX) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_bank_d           = other_bank;
          if (!full_pre[other_bank]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d = full_pre & ~clr_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      frame_err_q <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      do_en_q     <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      drop_q      <= drop_d;
      frame_err_q <= frame_err_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      do_en_q     <= (state_q == READ);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_addr}] <= {di_re, di_im};
    end
  end

  // Output register only loads on read cycles so data holds while do_en is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (state_q == READ) begin
      rd_data_q <= mem[{rd_bank_q, rd_cnt_q}];
    end
  end

`ifdef BITREV_IDX_EN
  logic [LOG_N-1:0] do_idx_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_idx_q <= '0;
    end else begin
      do_idx_q <= rd_cnt_q;
    end
  end

  assign do_idx = do_idx_q;
`endif

  assign do_en     = do_en_q;
  assign do_re     = rd_data_q[2*WIDTH-1:WIDTH];
  assign do_im     = rd_data_q[WIDTH-1:0];
  assign frame_err = frame_err_q;

endmodule

// File: doc/bitrev_reorder.md
Name: bitrev_reorder

Overview:
- Output reorder stage that sits directly downstream of the last radix-2^2 SDF stage of the FFT pipeline.
- The SDF chain emits each N-point frame in bit-reversed bin order. This block writes each frame into one half of a ping-pong buffer at bit-reversed addresses, then reads it back in natural bin order.
- It accepts back-to-back frames and produces gapless output frames, with no backpressure in either direction.

Parameters:
- N, 64, FFT point count; power of two, 4 <= N <= 4096.
- WIDTH, 16, data bit length (real and imaginary each).

Ports:
- clock  input  1  master clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- di_en  input  1  input data enable; high for N consecutive cycles per frame.
- di_re  input  WIDTH  input data, real part, bit-reversed order.
- di_im  input  WIDTH  input data, imaginary part, bit-reversed order.
- do_en  output  1  output data enable; high for N consecutive cycles per frame.
- do_re  output  WIDTH  output data, real part, natural order.
- do_im  output  WIDTH  output data, imaginary part, natural order.
- frame_err  output  1  one-cycle pulse when an input frame is aborted.

Behaviour:
- Storage: 2N x 2*WIDTH synchronous memory, addressed as {bank, addr[LOG_N-1:0]}, with a 1-cycle registered read. Two bank_full flags, one per bank.
- Writer:
  - Holds wr_bank and wr_cnt[LOG_N-1:0].
  - Each cycle di_en=1: write {di_re,di_im} to {wr_bank, bitrev(wr_cnt)}, where bitrev mirrors all LOG_N bits. Then wr_cnt++.
  - On the write with wr_cnt==N-1: set bank_full[wr_bank] next cycle, toggle wr_bank, wr_cnt wraps to 0.
- Abort:
  - di_en=0 while wr_cnt!=0 means a partial frame. The cycle after, wr_cnt returns to 0 and frame_err pulses high for exactly 1 cycle.
  - wr_bank is unchanged and the partial data is discarded; the next frame overwrites the same bank.
  - di_en=0 with wr_cnt==0: idle, no error.
- Drop: if bank_full[wr_bank]=1 when a frame starts (di_en=1, wr_cnt==0), the writes for the whole frame are suppressed. Counting proceeds normally, but neither wr_bank nor any flag changes. This cannot occur with compliant input and exists only as protection.
- Reader FSM:
  - States IDLE and READ, plus rd_bank and rd_cnt[LOG_N-1:0].
  - IDLE: if bank_full[rd_bank], go to READ with rd_cnt=0.
  - READ: present address {rd_bank, rd_cnt} and increment rd_cnt. At rd_cnt==N-1: clear bank_full[rd_bank] and toggle rd_bank. Then stay in READ with rd_cnt=0 if the other bank is full, otherwise return to IDLE. Back-to-back frames therefore produce no gap.
  - do_en is the READ-state flag delayed 1 cycle, aligned with the memory read data. do_re/do_im come from the memory output register.
- Latency: last input sample at cycle T, bank_full set at T+1, first read address presented at T+1, do_en=1 with bin 0 at T+2. do_en then stays high through bin N-1 at T+N+1.
- Simultaneous events:
  - A bank_full set and clear in the same cycle on different banks are independent.
  - A set and clear on the same bank cannot occur.
  - The writer tests the registered bank_full value, so a clear takes effect one cycle later.
- Reset (reset_n=0, asynchronous, any time including mid-frame): do_en=0, frame_err=0, do_re=do_im=0, wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, bank_full=00, FSM=IDLE. Any in-flight frame is lost and the output stops immediately. Memory contents are not cleared.
- While do_en=0, do_re/do_im hold their last value.

Optional Feature:
- Macro BITREV_IDX_EN.
- When defined, an extra output port do_idx [LOG_N-1:0] carries the natural bin index of the current output sample. It equals rd_cnt delayed 1 cycle, is valid when do_en=1, and resets to 0.
- When undefined, the port and its register are absent and all other behaviour is identical.

Test Plan (N=16, WIDTH=16):
- Reset: assert reset_n=0 mid-output with random stimulus -> do_en, frame_err, do_re, do_im are all 0 immediately. After release, no output until a full new frame is received.
- Single frame: input i (0..15) carries re=bitrev4(i), im=-bitrev4(i).
  - Last input at cycle T -> do_en rises at T+2 and is high for exactly 16 cycles.
  - do_re = 0,1,...,15; do_im = 0,-1,...,-15.
- Back-to-back: 3 frames with di_en continuously high for 48 cycles -> do_en continuously high for 48 cycles starting 2 cycles after sample 15. All three frames are in natural order and the bank alternation is verified.
- Abort: di_en high for 5 cycles then low -> frame_err pulses exactly once, 1 cycle after the drop, and no do_en. A following full frame is output correctly in bank 0.
- Gapped frames: 10 idle cycles between frames -> each output frame matches expected data, and the reader FSM returns to IDLE between frames.
- With BITREV_IDX_EN defined: single-frame test -> do_idx = 0..15 aligned with do_en; after reset do_idx=0.
